// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// A one-word pending slot keeps the output stream gap-free under a continuous producer.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             dout_o,
  output logic             dout_valid_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] pend_q;
  logic [CW-1:0]    cnt_q;
  logic             pend_full_q;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;

  assign din_ready_o   = ~pend_full_q & ~reset_i;
  assign accept        = din_valid_i & din_ready_o;
  assign last_bit      = (cnt_q == LAST_IDX);
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  assign out_bit       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  assign dout_valid_o  = (state_q == SHIFT);
  assign dout_o        = (state_q == SHIFT) ? out_bit : 1'b0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      pend_q      <= '0;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q <= din_i;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            shreg_q <= shreg_shifted;
            cnt_q   <= cnt_q + 1'b1;
            if (accept) begin
              pend_q      <= din_i;
              pend_full_q <= 1'b1;
            end
          end else if (pend_full_q) begin
            // pending word takes over the shifter; ready reopens next cycle
            shreg_q     <= pend_q;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
          end else if (accept) begin
            shreg_q <= din_i;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream pattern detectors. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `dout` with a qualifying `dout_valid`. It sits directly upstream of a serial sequence detector and drives that detector's `din`. A one-word pending buffer lets a producer that holds `din_valid` high sustain a gap-free stream at 1 bit/cycle.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is WIDTH ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  parallel word, sampled on handshake.
- `din_valid`  in  1  producer has a word on `din`.
- `din_ready`  out  1  block can take a word this cycle.
- `dout`  out  1  serial bit; 0 when `dout_valid`=0.
- `dout_valid`  out  1  `dout` carries a data bit this cycle.

## Operation
- Registers:
  - `shreg` [WIDTH]: active shifter.
  - `cnt` [clog2(WIDTH)]: bit index.
  - `active`: shifter holds a word.
  - `pend` [WIDTH]: pending word.
  - `pend_full`: pending slot occupied.
- Handshake:
  - `accept` = `din_valid` & `din_ready`.
  - `din_ready` = !`pend_full` & !`reset` (combinational).
- States:
  - IDLE (`active`=0).
  - SHIFT (`active`=1).
  - `pend_full` is orthogonal to both states.
- Outputs (combinational from registers):
  - `dout_valid` = `active`.
  - `dout` = `active` ? (MSB_FIRST ? `shreg`[WIDTH-1] : `shreg`[0]) : 0.
- IDLE, on `accept`: load `din` into `shreg`, `cnt`←0, go to SHIFT. The word does not enter `pend`.
- SHIFT, `cnt` < WIDTH-1:
  - Shift `shreg` toward the output end (MSB_FIRST: left; else: right), zero-fill.
  - `cnt`←`cnt`+1.
  - On `accept`: `pend`←`din`, `pend_full`←1.
- SHIFT, `cnt` = WIDTH-1 (last bit on `dout`). Priority:
  1. `pend_full`: `shreg`←`pend`, `pend_full`←0, `cnt`←0, stay in SHIFT.
  2. Else on `accept`: `shreg`←`din`, `cnt`←0, stay in SHIFT.
  3. Else go to IDLE. `shreg` is don't-care.
- No word is ever dropped or duplicated. A word can be accepted only when `pend_full`=0, so the pending slot never overflows.
- `din` contents are not checked; every value is legal.

## Timing
- Reset (synchronous, active-high):
  - Next edge: `active`=0, `pend_full`=0, `cnt`=0, `shreg`=0, `pend`=0.
  - Outputs while and after reset: `dout`=0, `dout_valid`=0.
  - `din_ready`=0 in every cycle `reset`=1, so no handshake completes in a reset cycle.
  - `din_ready`=1 in the first cycle after reset deasserts.
- Reset mid-word discards both the shifting word and the pending word. `dout_valid` is 0 from the cycle after the reset edge.
- Latency: a word accepted at edge k has its first bit on `dout` in cycle k+1 and its last bit in cycle k+WIDTH.
- Throughput: 1 bit/cycle. With `din_valid` held high, consecutive words appear with no idle cycle between them.
- Back-pressure: `din_ready` falls the cycle after a word enters `pend`. It rises again the cycle after `pend` moves into the shifter.
- The last-bit cycle with `pend_full`=0 and `din_valid`=1 completes a handshake. The word loads straight into the shifter with no gap.
- Upstream must hold `din`/`din_valid` stable until `accept`. The block does not check this.

## Test plan
- Reset: `reset`=1 for 3 cycles with `din_valid`=1, `din`=8'hFF → `din_ready`=0, `dout`=0, `dout_valid`=0 throughout. After release → `din_ready`=1 and no bits emitted.
- Single word: 8'hA5, MSB_FIRST=1, accepted at edge 0 →
  - Cycles 1–8: `dout_valid`=1, `dout`=1,0,1,0,0,1,0,1.
  - Cycle 9: `dout_valid`=0, `dout`=0.
- Back-to-back: 8'hCA then 8'h53 with `din_valid` held high →
  - 16 contiguous valid bits: 11001010 01010011.
  - `din_ready`=0 in cycles 2–8 and 1 again in cycle 9.
- LSB-first: MSB_FIRST=0, `din`=8'h0A → `dout`=0,1,0,1,0,0,0,0. With MSB_FIRST=1 the same word gives 0,0,0,0,1,0,1,0, ending in "1010" for the downstream detector.
- Direct load: pend empty, new word presented exactly in the last-bit cycle → handshake completes that cycle, next word's first bit follows with no gap, `pend_full` stays 0.
- Reset mid-operation: `reset` in bit 4 of 8'hF0 with 8'h0F pending → `dout_valid`=0 next cycle. After release with `din_valid`=0, no residual bits from either word appear.
